axi_slave_mem: RTL and testbench
================================

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 Parameter DATA_W, default 1024, SHALL set the width of the write and read data buses.
REQ-002 Parameter DEPTH, default 16 (power of two), SHALL set the number of DATA_W-bit memory words.
REQ-003 Parameter TCO, default 1, SHALL set the simulation clock-to-output delay applied to every register update.
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESET  in  1  reset, synchronous, active-high.
REQ-006 AWADDR  in  64  write burst start word address.
REQ-007 AWLEN  in  8  write burst length minus one.
REQ-008 AWVALID / AWREADY  in / out  1 / 1  write-address handshake.
REQ-009 WDATA  in  DATA_W  write beat data.
REQ-010 WLAST / WVALID / WREADY  in / in / out  1 / 1 / 1  write-data beat control.
REQ-011 BVALID / BREADY  out / in  1 / 1  write-response handshake.
REQ-012 ARADDR  in  64  read burst start word address.
REQ-013 ARLEN  in  8  read burst length minus one; tie to 0 for single-beat masters.
REQ-014 ARVALID / ARREADY  in / out  1 / 1  read-address handshake.
REQ-015 RDATA / RLAST / RVALID / RREADY  out / out / out / in  DATA_W / 1 / 1 / 1  read-data beat control.
REQ-016 wlast_err  out  1  sticky flag: WLAST position disagreed with AWLEN.

Function
REQ-017 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM SHALL have states R_IDLE, R_DATA; the two SHALL run independently.
REQ-018 AWREADY SHALL be 1 exactly in W_IDLE; on AWVALID&&AWREADY: latch word index = AWADDR mod DEPTH, latch AWLEN, clear write beat counter, go to W_DATA.
REQ-019 WREADY SHALL be 1 exactly in W_DATA; each WVALID&&WREADY cycle SHALL write WDATA to mem[index], then index = (index+1) mod DEPTH and beat counter +1.
REQ-020 Write burst SHALL end on the beat where WLAST=1 or beat counter == latched AWLEN, whichever comes first; next state W_RESP.
REQ-021 If on the ending beat WLAST and (beat counter == AWLEN) differ, wlast_err SHALL set to 1 and hold until reset.
REQ-022 BVALID SHALL be 1 exactly in W_RESP; on BVALID&&BREADY go to W_IDLE, so AWREADY returns the following cycle.
REQ-023 ARREADY SHALL be 1 exactly in R_IDLE; on ARVALID&&ARREADY: latch index = ARADDR mod DEPTH, latch ARLEN, clear read beat counter, go to R_DATA.
REQ-024 RVALID SHALL be 1 exactly in R_DATA, first asserted the cycle after the AR handshake (one-cycle latency).
REQ-025 RDATA SHALL equal mem[read index] combinationally while RVALID=1, else 0.
REQ-026 RLAST SHALL be 1 iff RVALID=1 and read beat counter == latched ARLEN.
REQ-027 Each RVALID&&RREADY SHALL advance read index mod DEPTH and beat counter +1; the handshake with RLAST=1 SHALL return to R_IDLE.
REQ-028 RVALID, RDATA, RLAST SHALL stay stable while RREADY=0; BVALID SHALL stay 1 while BREADY=0.
REQ-029 Index wrap: a burst crossing DEPTH-1 SHALL continue at word 0.
REQ-030 Same-cycle write beat and read beat to the same word: RDATA SHALL show the old value; the new value is visible from the next cycle.
REQ-031 AWLEN=255 / ARLEN=255 SHALL produce 256-beat bursts; beat counters SHALL be 9 bits wide.

Reset
REQ-032 ARESET=1 at a clock edge SHALL force W_IDLE and R_IDLE, clear all memory words, counters, indices and wlast_err, and drive AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0, RDATA=0 during reset.
REQ-033 Reset mid-burst SHALL abandon the burst with no response; AWREADY and ARREADY SHALL be 1 the first cycle after ARESET falls.

Verification
REQ-034 AW(addr 2, len 3), W beats 0xA,0xB,0xC,0xD (WLAST on 4th), BREADY=1 -> BVALID one cycle after the 4th beat; AR(addr 2, len 3) -> RDATA 0xA..0xD, RLAST on 4th beat only.
REQ-035 Write at addr 15 with len 1 (data 0x11, 0x22) -> mem[15]=0x11, mem[0]=0x22; a read of addr 0 with len 0 returns 0x22 with RLAST=1.
REQ-036 WLAST asserted on beat 2 of an AWLEN=3 burst -> burst ends after 2 beats, BVALID asserts, wlast_err=1 and stays 1 until reset.
REQ-037 RREADY held 0 for 3 cycles during a read burst -> RDATA/RLAST unchanged across those cycles; BREADY held 0 -> BVALID held and AWREADY stays 0.
REQ-038 Concurrent: write of 0x55 to word 4 in the same cycle a read beat of word 4 completes -> RDATA=old value; a subsequent read returns 0x55.
REQ-039 ARESET pulsed during beat 2 of a 4-beat write -> no BVALID, memory reads 0 everywhere, AWREADY=ARREADY=1 the first cycle after release.

Source files
------------

// File: rtl/axi_slave_mem.sv
// AXI-style burst slave backed by a DEPTH x DATA_W register memory.
// Independent write (AW/W/B) and read (AR/R) state machines; word-addressed, wrapping indices.
module axi_slave_mem #(
    parameter int DATA_W = 1024,
    parameter int DEPTH  = 16,
    parameter int TCO    = 1
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [63:0]       AWADDR,
    input  logic [7:0]        AWLEN,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [63:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              wlast_err,
    output logic [1:0]        o_w_state,
    output logic              o_r_state
);

    // Handshakes: a transfer happens on a rising edge where VALID && READY.
    // VALID never depends on READY; READY/VALID outputs here depend only on state and ARESET.

    localparam int IDX_W = $clog2(DEPTH);

    // TCO is kept for interface compatibility; updates are zero-delay so RTL and netlist agree.
    if (TCO < 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("axi_slave_mem: TCO must be >= 0 and DEPTH a power of two >= 2");
    end

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    w_state_t r_w_state, w_w_state_nxt;
    r_state_t r_r_state, w_r_state_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  r_w_idx, r_r_idx;
    logic [7:0]        r_w_len, r_r_len;
    logic [8:0]        r_w_cnt, r_r_cnt;
    logic              r_wlast_err;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
    logic w_w_at_len, w_r_at_len;
    logic w_unused_addr;

    assign w_w_at_len    = (r_w_cnt == {1'b0, r_w_len});
    assign w_r_at_len    = (r_r_cnt == {1'b0, r_r_len});
    assign w_aw_hs       = AWVALID && AWREADY;
    assign w_w_hs        = WVALID && WREADY;
    assign w_ar_hs       = ARVALID && ARREADY;
    assign w_r_hs        = RVALID && RREADY;
    assign w_unused_addr = ^{AWADDR[63:IDX_W], ARADDR[63:IDX_W]};

    assign wlast_err = r_wlast_err;
    assign o_w_state = r_w_state;
    assign o_r_state = r_r_state;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_w_state <= W_IDLE;
            r_r_state <= R_IDLE;
        end else begin
            r_w_state <= w_w_state_nxt;
            r_r_state <= w_r_state_nxt;
        end
    end

    // Outputs are forced low while ARESET is high, whatever the current state.
    always_comb begin
        w_w_state_nxt = r_w_state;
        AWREADY       = 1'b0;
        WREADY        = 1'b0;
        BVALID        = 1'b0;
        unique case (r_w_state)
            W_IDLE: begin
                AWREADY = !ARESET;
                if (AWVALID) w_w_state_nxt = W_DATA;
            end
            W_DATA: begin
                WREADY = !ARESET;
                if (WVALID && (WLAST || w_w_at_len)) w_w_state_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = !ARESET;
                if (BREADY) w_w_state_nxt = W_IDLE;
            end
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_r_state_nxt = r_r_state;
        ARREADY       = 1'b0;
        RVALID        = 1'b0;
        unique case (r_r_state)
            R_IDLE: begin
                ARREADY = !ARESET;
                if (ARVALID) w_r_state_nxt = R_DATA;
            end
            R_DATA: begin
                RVALID = !ARESET;
                if (RREADY && w_r_at_len) w_r_state_nxt = R_IDLE;
            end
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    // Combinational read port: a same-cycle write to this word shows up one cycle later.
    assign RDATA = RVALID ? r_mem[r_r_idx] : '0;
    assign RLAST = RVALID && w_r_at_len;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_w_idx     <= '0;
            r_w_len     <= '0;
            r_w_cnt     <= '0;
            r_r_idx     <= '0;
            r_r_len     <= '0;
            r_r_cnt     <= '0;
            r_wlast_err <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_w_idx <= AWADDR[IDX_W-1:0];
                r_w_len <= AWLEN;
                r_w_cnt <= '0;
            end else if (w_w_hs) begin
                r_mem[r_w_idx] <= WDATA;
                r_w_idx        <= r_w_idx + IDX_W'(1);
                r_w_cnt        <= r_w_cnt + 9'd1;
            end
            // A beat ends the burst whenever WLAST or the length match fires; flag any disagreement.
            if (w_w_hs && (WLAST != w_w_at_len)) r_wlast_err <= 1'b1;

            if (w_ar_hs) begin
                r_r_idx <= ARADDR[IDX_W-1:0];
                r_r_len <= ARLEN;
                r_r_cnt <= '0;
            end else if (w_r_hs) begin
                r_r_idx <= r_r_idx + IDX_W'(1);
                r_r_cnt <= r_r_cnt + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: directed scenarios plus randomized bursts against an
// array model of the memory and a sticky WLAST-error expectation.
module tb_axi_slave_mem;

    localparam int DW    = 64;
    localparam int DEPTH = 16;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [63:0]   AWADDR = '0;
    logic [7:0]    AWLEN = '0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [DW-1:0] WDATA = '0;
    logic          WLAST = 1'b0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic          BVALID;
    logic          BREADY = 1'b0;
    logic [63:0]   ARADDR = '0;
    logic [7:0]    ARLEN = '0;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic          wlast_err;
    logic [1:0]    o_w_state;
    logic          o_r_state;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic          err_exp;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] wdata_q[$];

    axi_slave_mem #(.DATA_W(DW), .DEPTH(DEPTH), .TCO(1)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .wlast_err(wlast_err), .o_w_state(o_w_state), .o_r_state(o_r_state)
    );

    // ---------------- clock / reset ----------------
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    function automatic int widx(input logic [63:0] a, input int b);
        return int'((a + 64'(b)) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        err_exp = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // Data comes from wdata_q; beats accepted = min(len, wlast_beat) + 1.
    task automatic write_burst(input logic [63:0] addr, input int len, input int wlast_beat,
                               input int bready_wait, input bit gaps);
        int end_beat;
        logic [DW-1:0] d;
        end_beat = (wlast_beat < len) ? wlast_beat : len;
        tick;
        AWADDR = addr; AWLEN = 8'(len); AWVALID = 1'b1;
        #1;
        checks++;
        if (AWREADY !== 1'b1) begin failures++; $display("FAIL awready_idle: got %b exp 1", AWREADY); end
        tick;
        AWVALID = 1'b0;
        for (int b = 0; b <= end_beat; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                WVALID = 1'b0;
                #1;
                checks++;
                if (WREADY !== 1'b1) begin failures++; $display("FAIL wready_gap: got %b exp 1", WREADY); end
                tick;
            end
            d = wdata_q.pop_front();
            WVALID = 1'b1; WDATA = d; WLAST = (b == wlast_beat);
            #1;
            checks++;
            if (WREADY !== 1'b1) begin failures++; $display("FAIL wready_beat%0d: got %b exp 1", b, WREADY); end
            model_mem[widx(addr, b)] = d;
            tick;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        if (wlast_beat != len) err_exp = 1'b1;
        wdata_q.delete();
        #1;
        checks++;
        if (BVALID !== 1'b1) begin failures++; $display("FAIL bvalid_after_last: got %b exp 1", BVALID); end
        checks++;
        if (WREADY !== 1'b0) begin failures++; $display("FAIL wready_in_resp: got %b exp 0", WREADY); end
        checks++;
        if (wlast_err !== err_exp) begin failures++; $display("FAIL wlast_err: got %b exp %b", wlast_err, err_exp); end
        for (int k = 0; k < bready_wait; k++) begin
            tick;
            checks++;
            if (BVALID !== 1'b1 || AWREADY !== 1'b0) begin
                failures++;
                $display("FAIL bvalid_hold: got bvalid=%b awready=%b exp 1/0", BVALID, AWREADY);
            end
        end
        BREADY = 1'b1;
        tick;
        BREADY = 1'b0;
        #1;
        checks++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            failures++;
            $display("FAIL b_done: got bvalid=%b awready=%b exp 0/1", BVALID, AWREADY);
        end
    endtask

    // Each beat stalls RREADY low for smin..smax cycles before accepting.
    task automatic read_burst(input logic [63:0] addr, input int len, input int smin, input int smax);
        logic [DW-1:0] e;
        bit last_e;
        int st;
        for (int b = 0; b <= len; b++) exp_q.push_back(model_mem[widx(addr, b)]);
        tick;
        ARADDR = addr; ARLEN = 8'(len); ARVALID = 1'b1;
        #1;
        checks++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            failures++;
            $display("FAIL ar_idle: got arready=%b rvalid=%b exp 1/0", ARREADY, RVALID);
        end
        tick;
        ARVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            e = exp_q.pop_front();
            last_e = (b == len);
            st = $urandom_range(smin, smax);
            for (int s = 0; s <= st; s++) begin
                RREADY = (s == st);
                #1;
                checks++;
                if (RVALID !== 1'b1 || RDATA !== e || RLAST !== last_e) begin
                    failures++;
                    $display("FAIL rbeat%0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b", b, RVALID, RDATA, RLAST, e, last_e);
                end
                tick;
            end
        end
        RREADY = 1'b0;
        #1;
        checks++;
        if (RVALID !== 1'b0 || RLAST !== 1'b0 || RDATA !== '0 || ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL r_done: got v=%b l=%b d=%h arready=%b exp 0/0/0/1", RVALID, RLAST, RDATA, ARREADY);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        ARESET = 1'b1;
        tick;
        checks++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0 || RDATA !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b rv=%b rl=%b rd=%h exp all 0",
                     AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, RDATA);
        end
        ARESET = 1'b0;
        #1;
        checks++;
        if (AWREADY !== 1'b1 || ARREADY !== 1'b1 || wlast_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got aw=%b ar=%b err=%b exp 1/1/0", AWREADY, ARREADY, wlast_err);
        end
        model_clear();
    endtask

    task automatic test_basic;
        wdata_q = '{64'hA, 64'hB, 64'hC, 64'hD};
        write_burst(64'd2, 3, 3, 0, 1'b0);
        read_burst(64'd2, 3, 0, 0);
    endtask

    task automatic test_wrap;
        wdata_q = '{64'h11, 64'h22};
        write_burst(64'd15, 1, 1, 0, 1'b0);
        read_burst(64'd0, 0, 0, 0);
        read_burst(64'd15, 1, 0, 0);
    endtask

    task automatic test_random;
        logic [63:0] a;
        int len, wl;
        for (int it = 0; it < 20; it++) begin
            a = {$urandom, $urandom};
            len = $urandom_range(0, 12);
            wl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len + 1) : len;
            for (int b = 0; b <= len; b++) wdata_q.push_back(rand_word());
            write_burst(a, len, wl, $urandom_range(0, 2), 1'b1);
            read_burst({$urandom, $urandom}, $urandom_range(0, 20), 0, 2);
        end
    endtask

    task automatic test_wlast_err;
        wdata_q = '{rand_word(), rand_word()};
        write_burst(64'd5, 3, 1, 0, 1'b0);
        wdata_q = '{rand_word(), rand_word()};
        write_burst(64'd9, 1, 99, 0, 1'b0);
        repeat (3) tick;
        checks++;
        if (wlast_err !== 1'b1) begin failures++; $display("FAIL wlast_err_sticky: got %b exp 1", wlast_err); end
        read_burst(64'd5, 5, 0, 0);
    endtask

    task automatic test_backpressure;
        wdata_q = '{rand_word(), rand_word(), rand_word()};
        write_burst(64'd0, 2, 2, 3, 1'b0);
        read_burst(64'd0, 2, 3, 3);
    endtask

    task automatic test_concurrent;
        logic [DW-1:0] old;
        wdata_q = '{rand_word() | 64'h1};
        write_burst(64'd4, 0, 0, 0, 1'b0);
        old = model_mem[4];
        tick;
        AWADDR = 64'd4; AWLEN = 8'd0; AWVALID = 1'b1;
        ARADDR = 64'd4; ARLEN = 8'd0; ARVALID = 1'b1;
        tick;
        AWVALID = 1'b0; ARVALID = 1'b0;
        WDATA = 64'h55; WVALID = 1'b1; WLAST = 1'b1; RREADY = 1'b1;
        #1;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== old || RLAST !== 1'b1 || WREADY !== 1'b1) begin
            failures++;
            $display("FAIL concurrent_old: got rv=%b d=%h rl=%b wr=%b exp 1/%h/1/1", RVALID, RDATA, RLAST, WREADY, old);
        end
        tick;
        model_mem[4] = 64'h55;
        WVALID = 1'b0; WLAST = 1'b0; RREADY = 1'b0; BREADY = 1'b1;
        #1;
        checks++;
        if (BVALID !== 1'b1) begin failures++; $display("FAIL concurrent_b: got %b exp 1", BVALID); end
        tick;
        BREADY = 1'b0;
        read_burst(64'd4, 0, 0, 0);
    endtask

    task automatic test_long_burst;
        for (int b = 0; b < 256; b++) wdata_q.push_back(rand_word());
        write_burst(64'd3, 255, 255, 1, 1'b1);
        read_burst(64'd3, 255, 0, 1);
    endtask

    task automatic test_reset_mid_burst;
        tick;
        AWADDR = 64'd6; AWLEN = 8'd3; AWVALID = 1'b1;
        tick;
        AWVALID = 1'b0;
        WDATA = rand_word(); WVALID = 1'b1; WLAST = 1'b0;
        tick;
        WDATA = rand_word(); ARESET = 1'b1;
        #1;
        checks++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0 || RDATA !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got aw=%b w=%b b=%b ar=%b rv=%b rl=%b exp all 0",
                     AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST);
        end
        tick;
        ARESET = 1'b0; WVALID = 1'b0;
        model_clear();
        #1;
        checks++;
        if (AWREADY !== 1'b1 || ARREADY !== 1'b1 || BVALID !== 1'b0 || wlast_err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release: got aw=%b ar=%b b=%b err=%b exp 1/1/0/0", AWREADY, ARREADY, BVALID, wlast_err);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (BVALID !== 1'b0) begin failures++; $display("FAIL midreset_no_b: got %b exp 0", BVALID); end
        end
        read_burst(64'd0, 15, 0, 1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_wrap();
        test_random();
        test_wlast_err();
        test_backpressure();
        test_concurrent();
        test_long_burst();
        test_reset_mid_burst();
        repeat (2) tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
